bure_stage_id_core: RTL and testbench

Instruction-decode stage of the Bure RV32I in-order pipeline, sitting between the fetch stage and execute. Each cycle it accepts one 32-bit instruction and its PC from fetch, decodes it into register addresses, a sign-extended immediate, an ALU operation and control flags, and registers the result for execute. It contains no register file; operand reads happen downstream using the decoded addresses.

---
 rtl/bure_stage_id_core.sv | 243 ++++++++++++++++++++++++
 tb/tb_bure_stage_id_core.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bure_stage_id_core.sv
// Bure RV32I instruction-decode stage: one instruction per cycle into a registered decode bundle.
// Define BURE_ID_M_EXT_EN to decode RV32M (funct7=0000001 on OP); otherwise those encodings are illegal.
module bure_stage_id_core #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_instr_valid,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0]  i_pc,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_pc,
  output logic [4:0]             o_rs1_addr,
  output logic [4:0]             o_rs2_addr,
  output logic [4:0]             o_rd_addr,
  output logic [DATA_WIDTH-1:0]  o_imm,
  output logic [2:0]             o_funct3,
  output logic [4:0]             o_alu_op,
  output logic                   o_alu_src_imm,
  output logic                   o_alu_src_pc,
  output logic                   o_reg_write,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_branch,
  output logic                   o_jump,
  output logic                   o_illegal
);

  localparam int unsigned REG_AW = 5;
  localparam int unsigned ALU_W  = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [ALU_W-1:0] ALU_ADD   = 5'd0;
  localparam logic [ALU_W-1:0] ALU_SUB   = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SLL   = 5'd2;
  localparam logic [ALU_W-1:0] ALU_SLT   = 5'd3;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XOR   = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SRL   = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SRA   = 5'd7;
  localparam logic [ALU_W-1:0] ALU_OR    = 5'd8;
  localparam logic [ALU_W-1:0] ALU_AND   = 5'd9;
  localparam logic [ALU_W-1:0] ALU_PASSB = 5'd10;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic [REG_AW-1:0]     rd;
    logic [DATA_WIDTH-1:0] imm;
    logic [2:0]            funct3;
    logic [ALU_W-1:0]      alu_op;
    logic                  src_imm;
    logic                  src_pc;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
  } bundle_t;

  // funct3 -> base ALU op; w_alt selects SUB/SRA
  function automatic logic [ALU_W-1:0] base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_legal;
  bundle_t     w_dec;
  bundle_t     r_bundle;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Combinational decode; a bubble decodes to an all-zero bundle
  always_comb begin
    w_dec   = '0;
    w_legal = 1'b1;
    if (i_instr_valid) begin
      w_dec.valid  = 1'b1;
      w_dec.pc     = i_pc;
      w_dec.rs1    = i_instr[19:15];
      w_dec.rs2    = i_instr[24:20];
      w_dec.rd     = i_instr[11:7];
      w_dec.funct3 = w_f3;
      case (w_opcode)
        OPC_LUI: begin
          w_dec.alu_op    = ALU_PASSB;
          w_dec.imm       = DATA_WIDTH'(w_imm_u);
          w_dec.src_imm   = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        OPC_AUIPC: begin
          w_dec.imm       = DATA_WIDTH'(w_imm_u);
          w_dec.src_pc    = 1'b1;
          w_dec.src_imm   = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        OPC_JAL: begin
          w_dec.imm       = DATA_WIDTH'(w_imm_j);
          w_dec.src_pc    = 1'b1;
          w_dec.jump      = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        OPC_JALR: begin
          w_legal         = (w_f3 == 3'b000);
          w_dec.imm       = DATA_WIDTH'(w_imm_i);
          w_dec.src_imm   = 1'b1;
          w_dec.jump      = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        OPC_BRANCH: begin
          w_legal      = (w_f3 != 3'b010) && (w_f3 != 3'b011);
          w_dec.alu_op = ALU_SUB;
          w_dec.imm    = DATA_WIDTH'(w_imm_b);
          w_dec.branch = 1'b1;
        end
        OPC_LOAD: begin
          w_legal         = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                            (w_f3 == 3'b100) || (w_f3 == 3'b101);
          w_dec.imm       = DATA_WIDTH'(w_imm_i);
          w_dec.src_imm   = 1'b1;
          w_dec.mem_read  = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        OPC_STORE: begin
          w_legal         = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
          w_dec.imm       = DATA_WIDTH'(w_imm_s);
          w_dec.src_imm   = 1'b1;
          w_dec.mem_write = 1'b1;
        end
        OPC_OPIMM: begin
          // Shift-immediates reuse the upper imm bits as a funct7 qualifier
          if (w_f3 == 3'b001)      w_legal = (w_f7 == F7_BASE);
          else if (w_f3 == 3'b101) w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          w_dec.alu_op    = base_op(w_f3, (w_f3 == 3'b101) && (w_f7 == F7_ALT));
          w_dec.imm       = DATA_WIDTH'(w_imm_i);
          w_dec.src_imm   = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        OPC_OP: begin
          w_dec.reg_write = 1'b1;
          if (w_f7 == F7_BASE) begin
            w_dec.alu_op = base_op(w_f3, 1'b0);
          end else if (w_f7 == F7_ALT) begin
            w_legal      = (w_f3 == 3'b000) || (w_f3 == 3'b101);
            w_dec.alu_op = base_op(w_f3, 1'b1);
          end else if (w_f7 == F7_MUL) begin
`ifdef BURE_ID_M_EXT_EN
            w_dec.alu_op = {2'b10, w_f3};
`else
            w_legal = 1'b0;
`endif
          end else begin
            w_legal = 1'b0;
          end
        end
        OPC_MISC: begin
        end
        OPC_SYSTEM: begin
          w_legal = (i_instr == 32'h0000_0073) || (i_instr == 32'h0010_0073);
        end
        default: w_legal = 1'b0;
      endcase

      if (!w_legal) begin
        w_dec.alu_op    = ALU_ADD;
        w_dec.src_imm   = 1'b0;
        w_dec.src_pc    = 1'b0;
        w_dec.reg_write = 1'b0;
        w_dec.mem_read  = 1'b0;
        w_dec.mem_write = 1'b0;
        w_dec.branch    = 1'b0;
        w_dec.jump      = 1'b0;
        w_dec.illegal   = 1'b1;
      end
      if (w_dec.rd == '0) w_dec.reg_write = 1'b0;
    end
  end

  // Bundle register: flush clears even while stalled, stall holds
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_bundle <= '0;
    else if (i_flush)  r_bundle <= '0;
    else if (!i_stall) r_bundle <= w_dec;
  end

  assign o_valid       = r_bundle.valid;
  assign o_pc          = r_bundle.pc;
  assign o_rs1_addr    = r_bundle.rs1;
  assign o_rs2_addr    = r_bundle.rs2;
  assign o_rd_addr     = r_bundle.rd;
  assign o_imm         = r_bundle.imm;
  assign o_funct3      = r_bundle.funct3;
  assign o_alu_op      = r_bundle.alu_op;
  assign o_alu_src_imm = r_bundle.src_imm;
  assign o_alu_src_pc  = r_bundle.src_pc;
  assign o_reg_write   = r_bundle.reg_write;
  assign o_mem_read    = r_bundle.mem_read;
  assign o_mem_write   = r_bundle.mem_write;
  assign o_branch      = r_bundle.branch;
  assign o_jump        = r_bundle.jump;
  assign o_illegal     = r_bundle.illegal;

endmodule

// File: tb/tb_bure_stage_id_core.sv
// Self-checking bench for bure_stage_id_core: expected bundles queued at drive time, compared after the edge.
module tb_bure_stage_id_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [31:0] o_imm;
  logic [2:0]  o_funct3;
  logic [4:0]  o_alu_op;
  logic        o_alu_src_imm, o_alu_src_pc, o_reg_write, o_mem_read;
  logic        o_mem_write, o_branch, o_jump, o_illegal;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [4:0]  alu;
    logic        simm;
    logic        spc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        ill;
  } obs_t;

  obs_t sb_q[$];
  obs_t exp_b, obs_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bure_stage_id_core #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .i_instr(instr), .i_pc(pc),
    .i_stall(stall), .i_flush(flush), .o_valid(o_valid), .o_pc(o_pc),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
    .o_imm(o_imm), .o_funct3(o_funct3), .o_alu_op(o_alu_op),
    .o_alu_src_imm(o_alu_src_imm), .o_alu_src_pc(o_alu_src_pc), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_branch(o_branch),
    .o_jump(o_jump), .o_illegal(o_illegal)
  );

  function automatic obs_t sample();
    return '{o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_imm, o_funct3, o_alu_op,
             o_alu_src_imm, o_alu_src_pc, o_reg_write, o_mem_read, o_mem_write,
             o_branch, o_jump, o_illegal};
  endfunction

  function automatic obs_t mk(logic [31:0] p, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                              logic [31:0] im, logic [2:0] f3, logic [4:0] alu, logic [7:0] fl);
    // fl = {simm, spc, rw, mr, mw, br, jp, ill}
    return '{1'b1, p, r1, r2, rd, im, f3, alu, fl[7], fl[6], fl[5], fl[4], fl[3], fl[2], fl[1], fl[0]};
  endfunction

  task automatic drive(logic v, logic [31:0] ins, logic [31:0] p, logic st, logic fl, obs_t e);
    instr_valid = v; instr = ins; pc = p; stall = st; flush = fl;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0; stall = 1'b0; flush = 1'b0;
    sb_q.push_back('0);
    #12;
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL reset_init got=%h want=%h", obs_b, exp_b); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_addi;
    drive(1, 32'h001101B3, 32'h100, 0, 0, mk(32'h100, 2, 1, 3, 0, 0, 0, 8'b0010_0000));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL add got=%h want=%h", obs_b, exp_b); end
    drive(1, 32'h80010193, 32'h104, 0, 0, mk(32'h104, 2, 0, 3, 32'hFFFFF800, 0, 0, 8'b1010_0000));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL addi_min got=%h want=%h", obs_b, exp_b); end
    drive(1, 32'h00110193, 32'h108, 0, 0, mk(32'h108, 2, 1, 3, 32'h1, 0, 0, 8'b1010_0000));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL addi_one got=%h want=%h", obs_b, exp_b); end
    drive(1, 32'h00500013, 32'h10C, 0, 0, mk(32'h10C, 0, 5, 0, 32'h5, 0, 0, 8'b1000_0000));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL rd_x0 got=%h want=%h", obs_b, exp_b); end
  endtask

  task automatic test_alt_and_illegal;
    drive(1, 32'h401101B3, 32'h200, 0, 0, mk(32'h200, 2, 1, 3, 0, 0, 1, 8'b0010_0000));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL sub got=%h want=%h", obs_b, exp_b); end
    drive(1, 32'h401141B3, 32'h204, 0, 0, mk(32'h204, 2, 1, 3, 0, 3'b100, 0, 8'b0000_0001));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL alt_xor_illegal got=%h want=%h", obs_b, exp_b); end
    drive(1, 32'h00000000, 32'h208, 0, 0, mk(32'h208, 0, 0, 0, 0, 0, 0, 8'b0000_0001));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL low_bits_illegal got=%h want=%h", obs_b, exp_b); end
    drive(1, 32'h00000073, 32'h20C, 0, 0, mk(32'h20C, 0, 0, 0, 0, 0, 0, 8'b0000_0000));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL ecall got=%h want=%h", obs_b, exp_b); end
`ifdef BURE_ID_M_EXT_EN
    drive(1, 32'h021101B3, 32'h210, 0, 0, mk(32'h210, 2, 1, 3, 0, 0, 5'd16, 8'b0010_0000));
`else
    drive(1, 32'h021101B3, 32'h210, 0, 0, mk(32'h210, 2, 1, 3, 0, 0, 0, 8'b0000_0001));
`endif
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL mul got=%h want=%h", obs_b, exp_b); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins [5];
    obs_t        ex  [5];
    ins[0] = 32'h123452B7; ex[0] = mk(32'h300, 8, 3, 5, 32'h12345000, 3'd5, 5'd10, 8'b1010_0000);
    ins[1] = 32'h00208463; ex[1] = mk(32'h304, 1, 2, 8, 32'h8, 0, 5'd1, 8'b0000_0100);
    ins[2] = 32'h0020A223; ex[2] = mk(32'h308, 1, 2, 4, 32'h4, 3'd2, 0, 8'b1000_1000);
    ins[3] = 32'h010000EF; ex[3] = mk(32'h30C, 0, 16, 1, 32'h10, 0, 0, 8'b0110_0010);
    ins[4] = 32'hFFC0A283; ex[4] = mk(32'h310, 1, 28, 5, 32'hFFFFFFFC, 3'd2, 0, 8'b1011_0000);
    for (int i = 0; i < 5; i++) begin
      drive(1, ins[i], 32'h300 + 32'(4 * i), 0, 0, ex[i]);
      obs_b = sample(); exp_b = sb_q.pop_front(); total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", i, obs_b, exp_b); end
    end
    drive(0, 32'h001101B3, 32'h314, 0, 0, '0);
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL bubble got=%h want=%h", obs_b, exp_b); end
  endtask

  task automatic test_stall_flush;
    obs_t held;
    held = mk(32'h400, 2, 1, 3, 0, 0, 0, 8'b0010_0000);
    drive(1, 32'h001101B3, 32'h400, 0, 0, held);
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL stall_load got=%h want=%h", obs_b, exp_b); end
    drive(1, 32'h80010193, 32'h404, 1, 0, held);
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL stall_hold got=%h want=%h", obs_b, exp_b); end
    drive(1, 32'h80010193, 32'h404, 1, 1, '0);
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL flush_stall got=%h want=%h", obs_b, exp_b); end
  endtask

  task automatic test_mid_reset;
    drive(1, 32'h001101B3, 32'h500, 0, 0, mk(32'h500, 2, 1, 3, 0, 0, 0, 8'b0010_0000));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL pre_reset got=%h want=%h", obs_b, exp_b); end
    rst = 1'b1;
    sb_q.push_back('0);
    #1;
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL async_reset got=%h want=%h", obs_b, exp_b); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    drive(1, 32'h00110193, 32'h600, 0, 0, mk(32'h600, 2, 1, 3, 32'h1, 0, 0, 8'b1010_0000));
    obs_b = sample(); exp_b = sb_q.pop_front(); total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL post_reset got=%h want=%h", obs_b, exp_b); end
  endtask

  initial begin
    test_reset();
    test_add_addi();
    test_alt_and_illegal();
    test_back_to_back();
    test_stall_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
